// File: rtl/thread_sched_pkg.sv
// Shared types and defaults for the hardware-thread scheduler.
// Struct fields are sized for the largest supported pool/timer; unused upper bits stay zero.
package thread_pkg;

  localparam int NUM_THRD_DEF = 8;
  localparam int TMR_W_DEF    = 8;
  localparam int THRD_W_MAX   = 8;
  localparam int TMR_W_MAX    = 16;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_SPAWN = 3'd1,
    CMD_KILL  = 3'd2,
    CMD_SLP   = 3'd3,
    CMD_WAKE  = 3'd4
  } thrd_cmd_e;

  typedef struct packed {
    logic                  valid;
    logic                  run;
    logic [THRD_W_MAX-1:0] parent;
    logic [TMR_W_MAX-1:0]  timer;
  } thrd_state_t;

endpackage

// File: rtl/thread_sched_if.sv
// Command/status bundle between the pipeline front end and the thread scheduler.
interface thread_sched_if import thread_pkg::*; #(
  parameter int NUM_THRD = NUM_THRD_DEF,
  parameter int TMR_W    = TMR_W_DEF
);
  localparam int THRD_W = $clog2(NUM_THRD);

  thrd_cmd_e            cmd;
  logic [THRD_W-1:0]    act_thrd;
  logic [THRD_W-1:0]    obj_thrd;
  logic [TMR_W-1:0]     slp_cyc;
  logic                 atomic;
  logic                 stall;
  logic [THRD_W-1:0]    cur_thrd;
  logic [THRD_W-1:0]    nxt_thrd;
  logic [THRD_W-1:0]    new_thrd;
  logic [NUM_THRD-1:0]  valid_thrd;
  logic [NUM_THRD-1:0]  run_thrd;
  logic                 thrd_full;
  logic                 thrd_of;
  logic                 invalid_op;
  logic                 error;

  modport master (
    output cmd, act_thrd, obj_thrd, slp_cyc, atomic, stall,
    input  cur_thrd, nxt_thrd, new_thrd, valid_thrd, run_thrd,
           thrd_full, thrd_of, invalid_op, error
  );

  modport slave (
    input  cmd, act_thrd, obj_thrd, slp_cyc, atomic, stall,
    output cur_thrd, nxt_thrd, new_thrd, valid_thrd, run_thrd,
           thrd_full, thrd_of, invalid_op, error
  );
endinterface

// File: rtl/thread_sched_rr_pick.sv
// Circular find-first-set over req, starting just after 'start'; returns 'start' when
// nothing else (or nothing at all) is requesting.
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [$clog2(N)-1:0] pick
);
  localparam int W = $clog2(N);

  always_comb begin
    int j;
    j    = 0;
    pick = start;
    // Walk from farthest to nearest so the nearest hit overwrites earlier ones.
    for (int k = N; k >= 1; k--) begin
      j = (int'(start) + k) % N;
      if (req[j]) pick = W'(j);
    end
  end
endmodule

// File: rtl/thread_sched.sv
// Round-robin hardware-thread scheduler with spawn/kill/sleep/wake, timed auto-wake,
// child reparenting on kill and a sticky deadlock flag.
module thread_sched import thread_pkg::*; #(
  parameter int NUM_THRD = NUM_THRD_DEF,
  parameter int TMR_W    = TMR_W_DEF
) (
  input logic           clk,
  input logic           rst,
  thread_sched_if.slave bus
);
  localparam int THRD_W = $clog2(NUM_THRD);

  thrd_state_t         st   [NUM_THRD];
  thrd_state_t         st_n [NUM_THRD];
  logic [NUM_THRD-1:0] valid_v, run_v, valid_n;
  logic [THRD_W-1:0]   cur, nxt, new_q, new_n, free_idx;
  logic                free_found, act_ok, obj_ok, tmr_idle;
  logic                full_q, of_q, inv_q, err_q, of_n, inv_n;

  always_comb begin
    valid_v  = '0;
    run_v    = '0;
    tmr_idle = 1'b1;
    for (int i = 0; i < NUM_THRD; i++) begin
      valid_v[i] = st[i].valid;
      run_v[i]   = st[i].run;
      if (st[i].timer != '0) tmr_idle = 1'b0;
    end
  end

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = NUM_THRD - 1; i >= 0; i--) begin
      if (!valid_v[i]) begin
        free_idx   = THRD_W'(i);
        free_found = 1'b1;
      end
    end
  end

  assign act_ok = valid_v[bus.act_thrd];
  assign obj_ok = valid_v[bus.obj_thrd] &&
                  ((bus.obj_thrd == bus.act_thrd) ||
                   (st[bus.obj_thrd].parent == THRD_W_MAX'(bus.act_thrd)));

  always_comb begin
    st_n    = st;
    new_n   = new_q;
    of_n    = 1'b0;
    inv_n   = 1'b0;
    valid_n = '0;
    for (int i = 0; i < NUM_THRD; i++) begin
      if (st[i].timer != '0) begin
        st_n[i].timer = st[i].timer - TMR_W_MAX'(1);
        if (st[i].timer == TMR_W_MAX'(1)) st_n[i].run = 1'b1;
      end
    end
    // Command updates come after the timer pass so they win on the same thread.
    case (bus.cmd)
      CMD_SPAWN: begin
        if (!act_ok) inv_n = 1'b1;
        else if (!free_found) of_n = 1'b1;
        else begin
          st_n[free_idx] = '{valid: 1'b1, run: 1'b1,
                             parent: THRD_W_MAX'(bus.act_thrd), timer: '0};
          new_n = free_idx;
        end
      end
      CMD_KILL: begin
        if (!act_ok || !obj_ok || bus.obj_thrd == '0) inv_n = 1'b1;
        else begin
          st_n[bus.obj_thrd].valid = 1'b0;
          st_n[bus.obj_thrd].run   = 1'b0;
          st_n[bus.obj_thrd].timer = '0;
          for (int i = 0; i < NUM_THRD; i++)
            if (st[i].parent == THRD_W_MAX'(bus.obj_thrd)) st_n[i].parent = '0;
        end
      end
      CMD_SLP: begin
        if (!act_ok || !obj_ok) inv_n = 1'b1;
        else begin
          st_n[bus.obj_thrd].run   = 1'b0;
          st_n[bus.obj_thrd].timer = TMR_W_MAX'(bus.slp_cyc);
        end
      end
      CMD_WAKE: begin
        if (!act_ok || !obj_ok) inv_n = 1'b1;
        else begin
          st_n[bus.obj_thrd].run   = 1'b1;
          st_n[bus.obj_thrd].timer = '0;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_THRD; i++) valid_n[i] = st_n[i].valid;
  end

  rr_pick #(.N(NUM_THRD)) u_rr_pick (
    .req   (run_v),
    .start (cur),
    .pick  (nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THRD; i++) st[i] <= '{default: '0};
      st[0].valid <= 1'b1;
      st[0].run   <= 1'b1;
      cur    <= '0;
      new_q  <= '0;
      full_q <= 1'b0;
      of_q   <= 1'b0;
      inv_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.stall) begin
      of_q  <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      st     <= st_n;
      if (!bus.atomic) cur <= nxt;
      new_q  <= new_n;
      full_q <= &valid_n;
      of_q   <= of_n;
      inv_q  <= inv_n;
      if (run_v == '0 && tmr_idle) err_q <= 1'b1;
    end
  end

  assign bus.cur_thrd   = cur;
  assign bus.nxt_thrd   = nxt;
  assign bus.new_thrd   = new_q;
  assign bus.valid_thrd = valid_v;
  assign bus.run_thrd   = run_v;
  assign bus.thrd_full  = full_q;
  assign bus.thrd_of    = of_q;
  assign bus.invalid_op = inv_q;
  assign bus.error      = err_q;
endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched (8 threads); expected values are hand-derived.
module tb_thread_sched;
  import thread_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  thread_sched_if #(.NUM_THRD(8), .TMR_W(8)) bus ();
  thread_sched #(.NUM_THRD(8), .TMR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input thrd_cmd_e c, input logic [2:0] act, input logic [2:0] obj,
                       input logic [7:0] slp);
    bus.cmd = c; bus.act_thrd = act; bus.obj_thrd = obj; bus.slp_cyc = slp;
    step();
    bus.cmd = CMD_NONE;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cur"},   32'(bus.cur_thrd),   32'd0);
    chk({tag, "_new"},   32'(bus.new_thrd),   32'd0);
    chk({tag, "_valid"}, 32'(bus.valid_thrd), 32'h01);
    chk({tag, "_run"},   32'(bus.run_thrd),   32'h01);
    chk({tag, "_full"},  32'(bus.thrd_full),  32'd0);
    chk({tag, "_of"},    32'(bus.thrd_of),    32'd0);
    chk({tag, "_inv"},   32'(bus.invalid_op), 32'd0);
    chk({tag, "_err"},   32'(bus.error),      32'd0);
  endtask

  initial begin
    logic [2:0] held;
    bus.cmd = CMD_NONE; bus.act_thrd = '0; bus.obj_thrd = '0; bus.slp_cyc = '0;
    bus.atomic = 1'b0; bus.stall = 1'b0;
    #1;

    // Reset, spawn to full, overflow
    rst = 1'b1;
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      issue(CMD_SPAWN, 3'd0, 3'd0, 8'd0);
      chk($sformatf("spawn_new%0d", k), 32'(bus.new_thrd), 32'(k));
    end
    chk("full_valid", 32'(bus.valid_thrd), 32'hFF);
    chk("full_flag",  32'(bus.thrd_full),  32'd1);
    for (int k = 1; k <= 7; k++)
      chk($sformatf("spawn_par%0d", k), 32'(dut.st[k].parent), 32'd0);
    issue(CMD_SPAWN, 3'd0, 3'd0, 8'd0);
    chk("of_pulse",  32'(bus.thrd_of),    32'd1);
    chk("of_valid",  32'(bus.valid_thrd), 32'hFF);
    chk("of_new",    32'(bus.new_thrd),   32'd7);
    chk("of_inv",    32'(bus.invalid_op), 32'd0);
    step();
    chk("of_clear",  32'(bus.thrd_of),    32'd0);

    // Round-robin over run_thrd = 1010_0101
    issue(CMD_SLP, 3'd0, 3'd1, 8'd0);
    issue(CMD_SLP, 3'd0, 3'd3, 8'd0);
    issue(CMD_SLP, 3'd0, 3'd4, 8'd0);
    issue(CMD_SLP, 3'd0, 3'd6, 8'd0);
    chk("rr_run", 32'(bus.run_thrd), 32'hA5);
    for (int k = 0; k < 8 && bus.cur_thrd != 3'd7; k++) step();
    chk("rr_sync", 32'(bus.cur_thrd), 32'd7);
    step(); chk("rr_0", 32'(bus.cur_thrd), 32'd0);
    step(); chk("rr_2", 32'(bus.cur_thrd), 32'd2);
    step(); chk("rr_5", 32'(bus.cur_thrd), 32'd5);
    step(); chk("rr_7", 32'(bus.cur_thrd), 32'd7);
    step(); chk("rr_0b", 32'(bus.cur_thrd), 32'd0);
    bus.atomic = 1'b1;
    held = bus.cur_thrd;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("atomic_hold%0d", k), 32'(bus.cur_thrd), 32'(held));
    end
    bus.atomic = 1'b0;
    step(); chk("atomic_release", 32'(bus.cur_thrd), 32'd2);

    // Permission checks
    do_reset();
    issue(CMD_SPAWN, 3'd0, 3'd0, 8'd0);   // thread 1, parent 0
    issue(CMD_SPAWN, 3'd1, 3'd0, 8'd0);   // thread 2, parent 1
    issue(CMD_SPAWN, 3'd0, 3'd0, 8'd0);   // thread 3, parent 0
    chk("perm_valid", 32'(bus.valid_thrd), 32'h0F);
    issue(CMD_KILL, 3'd3, 3'd2, 8'd0);
    chk("perm_inv",    32'(bus.invalid_op),    32'd1);
    chk("perm_keep2",  32'(bus.valid_thrd[2]), 32'd1);
    step();
    chk("perm_inv_clr", 32'(bus.invalid_op),  32'd0);
    issue(CMD_KILL, 3'd1, 3'd2, 8'd0);
    chk("kill_ok_inv", 32'(bus.invalid_op),   32'd0);
    chk("kill_ok_v2",  32'(bus.valid_thrd[2]), 32'd0);
    issue(CMD_KILL, 3'd0, 3'd0, 8'd0);
    chk("kill0_inv",   32'(bus.invalid_op),   32'd1);
    chk("kill0_valid", 32'(bus.valid_thrd),   32'h0B);
    issue(CMD_KILL, 3'd1, 3'd0, 8'd0);
    chk("kill0b_inv",  32'(bus.invalid_op),   32'd1);
    issue(CMD_SPAWN, 3'd6, 3'd0, 8'd0);
    chk("bad_act_inv", 32'(bus.invalid_op),   32'd1);

    // Timed sleep: thread 4 (respawn 2, then 4)
    issue(CMD_SPAWN, 3'd0, 3'd0, 8'd0);
    issue(CMD_SPAWN, 3'd0, 3'd0, 8'd0);
    chk("slp_new4", 32'(bus.new_thrd), 32'd4);
    issue(CMD_SLP, 3'd4, 3'd4, 8'd5);
    chk("slp_N", 32'(bus.run_thrd[4]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(); chk($sformatf("slp_N%0d", k), 32'(bus.run_thrd[4]), 32'd0);
    end
    step(); chk("slp_N5", 32'(bus.run_thrd[4]), 32'd1);

    issue(CMD_SLP, 3'd4, 3'd4, 8'd5);
    step();
    bus.stall = 1'b1;
    bus.cmd = CMD_KILL; bus.act_thrd = 3'd0; bus.obj_thrd = 3'd0;
    step(); chk("stall_no_inv", 32'(bus.invalid_op), 32'd0);
    step(); bus.cmd = CMD_NONE;
    bus.stall = 1'b0;
    step(); step(); step();
    chk("stall_N6", 32'(bus.run_thrd[4]), 32'd0);
    step(); chk("stall_N7", 32'(bus.run_thrd[4]), 32'd1);

    issue(CMD_SLP, 3'd4, 3'd4, 8'd5);
    step();
    issue(CMD_WAKE, 3'd4, 3'd4, 8'd0);
    chk("wake_N2", 32'(bus.run_thrd[4]), 32'd1);
    step(); step(); step();
    chk("wake_N5", 32'(bus.run_thrd[4]), 32'd1);

    issue(CMD_SLP, 3'd4, 3'd4, 8'd2);
    step();
    issue(CMD_SLP, 3'd4, 3'd4, 8'd0);
    chk("cmd_wins", 32'(bus.run_thrd[4]), 32'd0);
    issue(CMD_WAKE, 3'd0, 3'd4, 8'd0);
    chk("wake_parent", 32'(bus.run_thrd[4]), 32'd1);

    // Reparenting
    do_reset();
    issue(CMD_SPAWN, 3'd0, 3'd0, 8'd0);
    issue(CMD_SPAWN, 3'd1, 3'd0, 8'd0);
    issue(CMD_SPAWN, 3'd1, 3'd0, 8'd0);
    chk("rp_par2_pre", 32'(dut.st[2].parent), 32'd1);
    issue(CMD_KILL, 3'd0, 3'd1, 8'd0);
    chk("rp_valid", 32'(bus.valid_thrd),     32'h0D);
    chk("rp_par2",  32'(dut.st[2].parent),   32'd0);
    chk("rp_par3",  32'(dut.st[3].parent),   32'd0);
    issue(CMD_SLP, 3'd0, 3'd2, 8'd0);
    chk("rp_slp_inv", 32'(bus.invalid_op),   32'd0);
    chk("rp_slp_run", 32'(bus.run_thrd),     32'h09);

    // Deadlock and reset recovery
    do_reset();
    issue(CMD_SLP, 3'd0, 3'd0, 8'd0);
    chk("dl_run",  32'(bus.run_thrd), 32'd0);
    chk("dl_err0", 32'(bus.error),    32'd0);
    step(); chk("dl_err1", 32'(bus.error), 32'd1);
    step(); step();
    chk("dl_sticky", 32'(bus.error), 32'd1);
    rst = 1'b1;
    step();
    chk_reset_vals("rst2");
    rst = 1'b0;
    step();
    chk("post_rst_err", 32'(bus.error),    32'd0);
    chk("post_rst_run", 32'(bus.run_thrd), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/thread_sched.md
# thread_sched

Parametrised hardware-thread scheduler for the IF stage, successor to the fixed 8-thread controller. It holds per-thread valid/run/parent state for `NUM_THRD` threads and picks the next runnable thread round-robin. It executes one spawn/kill/sleep/wake command per cycle with parent-based permission checks. It adds timed sleep with per-thread auto-wake counters, child reparenting on kill, and deadlock detection.

## Interface
- `NUM_THRD`, 8: number of hardware threads; must be at least 2.
- `THRD_W`, `$clog2(NUM_THRD)`: thread index width.
- `TMR_W`, 8: sleep-timer width.

- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `cmd`  in  `thrd_cmd_e`: command; one of `CMD_NONE`, `CMD_SPAWN`, `CMD_KILL`, `CMD_SLP`, `CMD_WAKE`.
- `act_thrd`  in  `THRD_W`: thread issuing the command.
- `obj_thrd`  in  `THRD_W`: target of kill, sleep or wake. Ignored for spawn.
- `slp_cyc`  in  `TMR_W`: sleep duration for `CMD_SLP`; 0 means sleep until woken.
- `atomic`  in  1: hold `cur_thrd` this cycle.
- `stall`  in  1: freeze all state, timers and flags.
- `cur_thrd`  out  `THRD_W`: thread currently issuing.
- `nxt_thrd`  out  `THRD_W`: combinational; the thread `cur_thrd` moves to on the next advancing edge.
- `new_thrd`  out  `THRD_W`: index allocated by the last successful spawn.
- `valid_thrd`  out  `NUM_THRD`: allocated threads.
- `run_thrd`  out  `NUM_THRD`: valid threads that are not sleeping.
- `thrd_full`  out  1: all threads are valid.
- `thrd_of`  out  1: one-cycle pulse; spawn attempted while full.
- `invalid_op`  out  1: one-cycle pulse; command rejected by the permission rules.
- `error`  out  1: sticky deadlock flag.

## Operation
- **Reset values:** thread 0 valid and running, `parent[0]=0`. `cur_thrd=0`, `new_thrd=0`, `valid_thrd=run_thrd=1`. All timers 0. `thrd_full`, `thrd_of`, `invalid_op` and `error` are 0.
- **Permission:** `act_thrd` must be valid. For kill, sleep and wake, `obj_thrd` must also be valid and must equal `act_thrd` or have `parent[obj_thrd]==act_thrd`.
  - Thread 0 can never be killed.
  - Any violation leaves state unchanged and pulses `invalid_op`.
- **Spawn:** allocate the lowest-index invalid thread. Set its valid and run bits, set its parent to `act_thrd`, clear its timer, and set `new_thrd` to its index. If the pool is full, nothing changes and `thrd_of` pulses.
- **Kill:** clear valid, run and timer for `obj_thrd`. Every thread whose parent was `obj_thrd` is reparented to thread 0 on the same edge.
- **Sleep:** clear the run bit and load the timer with `slp_cyc`.
- **Wake:** set the run bit and clear the timer. Waking a thread that is already running is legal and a no-op.
- **Timers:** every non-stalled edge, each nonzero timer decrements. When a timer goes from 1 to 0, that thread's run bit is set on the same edge.
  - If a command targets the same thread on the same edge, the command wins.
- **Round-robin selection:** `nxt_thrd` is the first set bit of the registered `run_thrd`, searching circularly from `cur_thrd+1`, wrapping at `NUM_THRD-1`.
  - If only `cur_thrd` is runnable, `nxt_thrd=cur_thrd`.
  - If no thread is runnable, `nxt_thrd=cur_thrd`.
- **Advance:** on each edge with `!stall && !atomic`, `cur_thrd <= nxt_thrd`. Selection uses pre-command state, so a thread slept or killed on edge N may still be the one selected at N.
- **Deadlock:** if `run_thrd` is all zero and every timer is 0 while not stalled, `error` sets on the next edge and stays set until `rst`.
- **Stall:** when `stall` is high, the command is ignored and no flags pulse.

## Timing
- A command sampled at edge N is visible in `valid_thrd`, `run_thrd`, `new_thrd` and `thrd_full` after edge N. `thrd_of` and `invalid_op` are high for exactly the cycle after edge N.
- A sleep with `slp_cyc=T>0` issued at edge N sets the run bit again at edge N+T, provided there is no stall. Each stalled cycle adds one cycle of delay.
- `thrd_full` is registered and is equal to `&valid_thrd`.
- `rst` overrides everything on the edge where it is high, including an in-flight timer or command.

## Structure
- Package `thread_pkg` holds:
  - `thrd_cmd_e` (3-bit enum);
  - the default constants `NUM_THRD_DEF` and `TMR_W_DEF`;
  - the per-thread struct `thrd_state_t` {valid, run, parent, timer}.
- Sub-module `rr_pick`: a combinational circular find-first-set over `NUM_THRD` bits starting after a given index. It is instantiated once for `nxt_thrd`.
- Spawn allocation uses a plain lowest-index find-first-clear; it is not a separate module.

## Test plan
- **Reset, spawn, full:** reset, then thread 0 spawns 7 times (`NUM_THRD=8`).
  - Required: `new_thrd` = 1..7, all parents 0, `valid_thrd=8'hFF`, `thrd_full=1`.
  - An 8th spawn pulses `thrd_of` for one cycle and leaves state unchanged.
- **Round-robin:** `run_thrd=8'b1010_0101`, `cur_thrd=7`, no atomic.
  - Required: `cur_thrd` sequence 0, 2, 5, 7, 0.
  - With `atomic` held for 3 cycles, `cur_thrd` holds its value for those 3 cycles.
- **Permission:** thread 1 (child of 0) spawns thread 2; thread 3 then kills thread 2.
  - Required: `invalid_op` pulses once and `valid_thrd[2]` stays 1.
  - Thread 1 killing thread 2 succeeds. Any kill of thread 0 pulses `invalid_op`.
- **Timed sleep:** thread 4 sleeps itself with `slp_cyc=5`.
  - Required: `run_thrd[4]` goes low after edge N and high after edge N+5.
  - Repeat with `stall` high for 2 cycles in between: it returns after edge N+7.
  - A wake issued at N+2 restores it after edge N+2.
- **Reparenting:** thread 0 spawns 1; thread 1 spawns 2 and 3; thread 0 kills 1.
  - Required: `parent[2]=parent[3]=0`.
  - Thread 0 can then sleep thread 2 without `invalid_op`.
- **Deadlock and reset:** thread 0 is the only thread and sleeps itself with `slp_cyc=0`.
  - Required: `error=1` from the following cycle and stays set.
  - Asserting `rst` for one cycle restores all reset values.
